// File: rtl/icache.sv
// Direct-mapped instruction cache: 64 lines of 4 words.
// Hits answer next cycle; misses refill one word at a time.
module icache #(
    parameter  int INDEX_W  = 6,
    localparam int OFFSET_W = 4,
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] IC_addr,
    input  logic        IC_addr_sgn,
    output logic [31:0] IC_ins,
    output logic        IC_ins_sgn,
    input  logic        ROB_jp_wrong,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_valid,
    input  logic [31:0] MC_data
);

    localparam int LINES = 2 ** INDEX_W;
    localparam int LW    = 32 - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [LW-1:0] line_q, line_d;
    logic [1:0]    woff_q, woff_d;
    logic [95:0]   lbuf_q, lbuf_d;
    logic          mc_req_q, mc_req_d;
    logic [31:0]   mc_addr_q, mc_addr_d;
    logic          ins_sgn_q, ins_sgn_d;
    logic [31:0]   ins_q, ins_d;
    logic          install;

    logic [127:0]     data_q [LINES];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    logic [INDEX_W-1:0] req_idx, ref_idx;
    logic [TAG_W-1:0]   req_tag, ref_tag;
    logic [1:0]         req_word;
    logic               hit, accept;
    logic [31:0]        hit_word, resp_word;
    logic               unused_addr;

    assign req_idx     = IC_addr[OFFSET_W +: INDEX_W];
    assign req_tag     = IC_addr[31 -: TAG_W];
    assign req_word    = IC_addr[3:2];
    assign ref_idx     = line_q[INDEX_W-1:0];
    assign ref_tag     = line_q[INDEX_W +: TAG_W];
    assign unused_addr = ^IC_addr[1:0];

    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept    = IC_addr_sgn && !ROB_jp_wrong && !ins_sgn_q;
    assign hit_word  = data_q[req_idx][{req_word, 5'b0} +: 32];
    assign resp_word = data_q[ref_idx][{woff_q, 5'b0} +: 32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        line_d    = line_q;
        woff_d    = woff_q;
        lbuf_d    = lbuf_q;
        mc_req_d  = mc_req_q;
        mc_addr_d = mc_addr_q;
        ins_sgn_d = 1'b0;
        ins_d     = ins_q;
        install   = 1'b0;
        if (ROB_jp_wrong) pend_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && hit) begin
                    ins_sgn_d = 1'b1;
                    ins_d     = hit_word;
                end else if (accept) begin
                    state_d   = REFILL;
                    line_d    = IC_addr[31:OFFSET_W];
                    woff_d    = req_word;
                    cnt_d     = 2'd0;
                    pend_d    = 1'b1;
                    mc_req_d  = 1'b1;
                    mc_addr_d = {IC_addr[31:OFFSET_W], 4'b0};
                end
            end
            REFILL: begin
                if (mc_req_q && MC_valid) begin
                    mc_req_d = 1'b0;
                    lbuf_d   = {MC_data, lbuf_q[95:32]};
                    if (cnt_q == 2'd3) begin
                        install = 1'b1;
                        state_d = (pend_q && !ROB_jp_wrong) ? RESP : IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (!mc_req_q) begin
                    // one idle cycle separates consecutive word requests
                    mc_req_d  = 1'b1;
                    mc_addr_d = {line_q, cnt_q, 2'b00};
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!ROB_jp_wrong) begin
                    ins_sgn_d = 1'b1;
                    ins_d     = resp_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            pend_q    <= 1'b0;
            line_q    <= '0;
            woff_q    <= 2'd0;
            lbuf_q    <= '0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= 32'd0;
            ins_sgn_q <= 1'b0;
            ins_q     <= 32'd0;
            valid_q   <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            line_q    <= line_d;
            woff_q    <= woff_d;
            lbuf_q    <= lbuf_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
            ins_sgn_q <= ins_sgn_d;
            ins_q     <= ins_d;
            if (install) valid_q[ref_idx] <= 1'b1;
        end
    end

    // storage arrays carry no reset; the valid bits guard them
    always_ff @(posedge clk) begin
        if (!rst && rdy && install) begin
            data_q[ref_idx] <= {MC_data, lbuf_q};
            tag_q[ref_idx]  <= ref_tag;
        end
    end

    assign IC_ins     = ins_q;
    assign IC_ins_sgn = ins_sgn_q;
    assign MC_req     = mc_req_q;
    assign MC_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a
// line-level cache model and a latency-programmable memory.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] IC_addr = 32'd0;
    logic        IC_addr_sgn = 1'b0;
    logic [31:0] IC_ins;
    logic        IC_ins_sgn;
    logic        ROB_jp_wrong = 1'b0;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_valid = 1'b0;
    logic [31:0] MC_data = 32'd0;

    int checks = 0;
    int errors = 0;

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IC_addr(IC_addr), .IC_addr_sgn(IC_addr_sgn),
        .IC_ins(IC_ins), .IC_ins_sgn(IC_ins_sgn),
        .ROB_jp_wrong(ROB_jp_wrong),
        .MC_req(MC_req), .MC_addr(MC_addr),
        .MC_valid(MC_valid), .MC_data(MC_data)
    );

    always #5 clk = ~clk;

    // reference model: which tag each line currently holds
    bit          mv [64];
    logic [21:0] mt [64];

    logic [31:0] mc_log [$];
    logic [31:0] resp_q [$];
    int          cons_cnt = 0;
    int          lat = 3;

    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] r;
        if (a[31:4] == 28'd0) begin
            case (a[3:2])
                2'd0: return 32'h11;
                2'd1: return 32'h22;
                2'd2: return 32'h33;
                default: return 32'h44;
            endcase
        end
        r = a * 32'h9E37_79B1;
        return r ^ 32'h5A5A_0F0F;
    endfunction

    // memory controller and response monitor, sampled just after each edge
    initial begin
        bit          busy;
        int          wcnt;
        logic [31:0] raddr;
        busy = 0;
        wcnt = 0;
        raddr = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy = 0;
                MC_valid = 1'b0;
            end else if (rdy) begin
                if (MC_valid) begin
                    MC_valid = 1'b0;
                    busy = 0;
                    cons_cnt++;
                    checks++;
                    if (MC_req !== 1'b0) begin
                        errors++;
                        $display("FAIL mc_req_gap got %0b want 0", MC_req);
                    end
                end else if (busy) begin
                    if (wcnt == 0) begin
                        MC_valid = 1'b1;
                        MC_data = mem(raddr);
                    end else begin
                        wcnt--;
                    end
                end else if (MC_req === 1'b1) begin
                    busy = 1;
                    raddr = MC_addr;
                    mc_log.push_back(MC_addr);
                    wcnt = lat - 1;
                end
                if (IC_ins_sgn === 1'b1) resp_q.push_back(IC_ins);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mv[i] = 0;
    endtask

    task automatic check_lines(input int s_mc, input logic [31:0] a,
                               input string nm);
        logic [31:0] base;
        base = {a[31:4], 4'b0};
        checks++;
        if (mc_log.size() != s_mc + 4) begin
            errors++;
            $display("FAIL %s mc_count got %0d want %0d", nm,
                     mc_log.size() - s_mc, 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mc_log[s_mc + i] !== base + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL %s mc_addr%0d got %h want %h", nm, i,
                             mc_log[s_mc + i], base + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input bit hold,
                            input string nm);
        int s_mc, s_r, l;
        bit hit;
        logic [5:0]  idx;
        logic [21:0] tg;
        idx = a[9:4];
        tg = a[31:10];
        hit = mv[idx] && (mt[idx] == tg);
        s_mc = mc_log.size();
        s_r = resp_q.size();
        @(negedge clk);
        IC_addr = a;
        IC_addr_sgn = 1'b1;
        l = 0;
        while (resp_q.size() == s_r && l < 300) begin
            @(negedge clk);
            l++;
        end
        if (hold) @(negedge clk);
        IC_addr_sgn = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (resp_q.size() != s_r + 1) begin
            errors++;
            $display("FAIL %s resp_count got %0d want 1", nm,
                     resp_q.size() - s_r);
        end else begin
            checks++;
            if (resp_q[s_r] !== mem(a)) begin
                errors++;
                $display("FAIL %s data got %h want %h", nm,
                         resp_q[s_r], mem(a));
            end
        end
        if (hit) begin
            checks++;
            if (l != 1) begin
                errors++;
                $display("FAIL %s hit_latency got %0d want 1", nm, l);
            end
            checks++;
            if (mc_log.size() != s_mc) begin
                errors++;
                $display("FAIL %s hit_mc_req got %0d want 0", nm,
                         mc_log.size() - s_mc);
            end
        end else begin
            checks++;
            if (l <= 1) begin
                errors++;
                $display("FAIL %s miss_latency got %0d want >1", nm, l);
            end
            check_lines(s_mc, a, nm);
            mv[idx] = 1;
            mt[idx] = tg;
        end
    endtask

    task automatic wait_cons(input int target, input string nm);
        int t;
        t = 0;
        while (cons_cnt < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cons_cnt < target) begin
            errors++;
            $display("FAIL %s word_timeout got %0d want %0d", nm,
                     cons_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (IC_ins_sgn !== 1'b0 || IC_ins !== 32'd0 ||
            MC_req !== 1'b0 || MC_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset got sgn=%b ins=%h req=%b addr=%h want 0",
                     IC_ins_sgn, IC_ins, MC_req, MC_addr);
        end
    endtask

    task automatic test_cold_hit_conflict();
        lat = 3;
        do_fetch(32'h0000_0000, 0, "cold_miss");
        do_fetch(32'h0000_0008, 0, "hit_after_refill");
        do_fetch(32'h0000_0400, 0, "conflict_new_tag");
        do_fetch(32'h0000_0000, 0, "conflict_refetch");
        do_fetch(32'h0000_000C, 1, "held_request");
    endtask

    task automatic test_flush_refill();
        int s_mc, s_r, c0;
        logic [31:0] a;
        a = 32'h0000_1234 & 32'hFFFF_FFFC;
        lat = 2;
        s_mc = mc_log.size();
        s_r = resp_q.size();
        c0 = cons_cnt;
        @(negedge clk);
        IC_addr = a;
        IC_addr_sgn = 1'b1;
        wait_cons(c0 + 2, "flush_refill");
        IC_addr_sgn = 1'b0;
        ROB_jp_wrong = 1'b1;
        @(negedge clk);
        ROB_jp_wrong = 1'b0;
        wait_cons(c0 + 4, "flush_refill");
        repeat (5) @(negedge clk);
        checks++;
        if (resp_q.size() != s_r) begin
            errors++;
            $display("FAIL flush_refill resp got %0d want 0",
                     resp_q.size() - s_r);
        end
        check_lines(s_mc, a, "flush_refill");
        mv[a[9:4]] = 1;
        mt[a[9:4]] = a[31:10];
        do_fetch(a, 0, "flush_then_hit");
    endtask

    task automatic test_flush_resp();
        int s_mc, s_r, c0;
        logic [31:0] a;
        a = 32'h00AB_C0E8;
        lat = 1;
        s_mc = mc_log.size();
        s_r = resp_q.size();
        c0 = cons_cnt;
        @(negedge clk);
        IC_addr = a;
        IC_addr_sgn = 1'b1;
        wait_cons(c0 + 4, "flush_resp");
        IC_addr_sgn = 1'b0;
        ROB_jp_wrong = 1'b1;
        @(negedge clk);
        ROB_jp_wrong = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (resp_q.size() != s_r) begin
            errors++;
            $display("FAIL flush_resp resp got %0d want 0",
                     resp_q.size() - s_r);
        end
        check_lines(s_mc, a, "flush_resp");
        mv[a[9:4]] = 1;
        mt[a[9:4]] = a[31:10];
        do_fetch(a, 0, "flush_resp_hit");
    endtask

    task automatic test_flush_hit();
        int s_r;
        s_r = resp_q.size();
        @(negedge clk);
        IC_addr = 32'h0000_0004;
        IC_addr_sgn = 1'b1;
        ROB_jp_wrong = 1'b1;
        @(negedge clk);
        IC_addr_sgn = 1'b0;
        ROB_jp_wrong = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (resp_q.size() != s_r) begin
            errors++;
            $display("FAIL flush_hit resp got %0d want 0",
                     resp_q.size() - s_r);
        end
    endtask

    task automatic test_rdy_then_rst();
        int s_mc, s_r, c0, c1;
        logic [31:0] a, base;
        a = 32'h0003_0050;
        base = {a[31:4], 4'b0};
        lat = 3;
        s_r = resp_q.size();
        c0 = cons_cnt;
        @(negedge clk);
        IC_addr = a;
        IC_addr_sgn = 1'b1;
        wait_cons(c0 + 1, "rdy_freeze");
        @(negedge clk);
        rdy = 1'b0;
        checks++;
        if (MC_req !== 1'b1 || MC_addr !== base + 32'd4) begin
            errors++;
            $display("FAIL rdy_reissue got req=%b addr=%h want 1 %h",
                     MC_req, MC_addr, base + 32'd4);
        end
        c1 = cons_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (MC_req !== 1'b1 || MC_addr !== base + 32'd4 ||
                IC_ins_sgn !== 1'b0 || cons_cnt != c1) begin
                errors++;
                $display("FAIL rdy_frozen%0d got req=%b addr=%h sgn=%b",
                         i, MC_req, MC_addr, IC_ins_sgn);
            end
        end
        rdy = 1'b1;
        wait_cons(c0 + 2, "rdy_resume");
        rst = 1'b1;
        IC_addr_sgn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        checks++;
        if (MC_req !== 1'b0 || IC_ins_sgn !== 1'b0 || IC_ins !== 32'd0) begin
            errors++;
            $display("FAIL rst_refill got req=%b sgn=%b ins=%h want 0",
                     MC_req, IC_ins_sgn, IC_ins);
        end
        s_mc = mc_log.size();
        repeat (6) @(negedge clk);
        checks++;
        if (mc_log.size() != s_mc || resp_q.size() != s_r) begin
            errors++;
            $display("FAIL rst_quiet got mc=%0d resp=%0d want 0 0",
                     mc_log.size() - s_mc, resp_q.size() - s_r);
        end
        do_fetch(32'h0000_0008, 0, "miss_after_rst");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [21:0] tg;
        logic [5:0]  idx;
        for (int n = 0; n < 30; n++) begin
            tg = 22'($urandom_range(0, 2));
            idx = 6'($urandom_range(0, 3));
            a = {tg, idx, 2'($urandom_range(0, 3)), 2'b00};
            lat = $urandom_range(1, 4);
            do_fetch(a, ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_cold_hit_conflict();
        test_flush_refill();
        test_flush_resp();
        test_flush_hit();
        test_rdy_then_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
